// File: rtl/timer_share_ctrl.sv
// Round-robin controller that time-shares one up-counter between NREQ requesters.
// A winner gets the counter for len cycles, then receives a one-cycle done pulse.
module timer_share_ctrl #(
    parameter int NREQ = 4,
    parameter int CW   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    input  logic               abort,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic [NREQ-1:0]    done,
    output logic [CW-1:0]      cout
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic [NREQ-1:0] r_grant;
    logic            r_busy;
    logic [NREQ-1:0] r_done;
    logic [CW-1:0]   r_cout;
    logic [CW-1:0]   r_target;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;

    logic            w_found;
    logic [PW-1:0]   w_winner;
    logic [CW-1:0]   w_winLen;
    logic [NREQ-1:0] w_winOneHot;
    logic [PW-1:0]   w_nextPtr;

    assign grant = r_grant;
    assign busy  = r_busy;
    assign done  = r_done;
    assign cout  = r_cout;

    // First requester found scanning upward from r_ptr, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % NREQ]) begin
                w_found  = 1'b1;
                w_winner = PW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_winLen    = len[int'(w_winner)*CW +: CW];
    assign w_winOneHot = NREQ'(1) << w_winner;
    assign w_nextPtr   = (r_owner == PW'(NREQ-1)) ? '0 : r_owner + PW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_done   <= '0;
            r_cout   <= '0;
            r_target <= '0;
            r_ptr    <= '0;
            r_owner  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= '0;
                    r_cout <= '0;
                    if (w_found) begin
                        r_grant  <= w_winOneHot;
                        r_busy   <= 1'b1;
                        r_target <= w_winLen;
                        r_owner  <= w_winner;
                        // A zero-length job skips RUN and completes on the grant edge.
                        if (w_winLen == '0) begin
                            r_state <= S_DONE;
                            r_done  <= w_winOneHot;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= '0;
                        r_cout  <= '0;
                        r_ptr   <= w_nextPtr;
                    end else if (r_cout == r_target - CW'(1)) begin
                        r_state <= S_DONE;
                        r_done  <= r_grant;
                    end else begin
                        r_cout <= r_cout + CW'(1);
                    end
                end
                S_DONE: begin
                    // Abort here behaves like normal completion: the pulse already went out.
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= '0;
                    r_cout  <= '0;
                    r_ptr   <= w_nextPtr;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= '0;
                    r_cout  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_share_ctrl.sv
// Directed bench for timer_share_ctrl with hand-computed expected values.
module tb_timer_share_ctrl;

    localparam int NREQ = 4;
    localparam int CW   = 8;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic               abort;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic [NREQ-1:0]    done;
    logic [CW-1:0]      cout;

    int checks;
    int errors;

    timer_share_ctrl #(.NREQ(NREQ), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .abort (abort),
        .grant (grant),
        .busy  (busy),
        .done  (done),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] reqV, input logic [NREQ*CW-1:0] lenV, input logic abortV);
        req   = reqV;
        len   = lenV;
        abort = abortV;
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [NREQ-1:0] g, input logic b,
                            input logic [NREQ-1:0] d, input logic [CW-1:0] c);
        checkOutput({tag, ".grant"}, 32'(grant), 32'(g));
        checkOutput({tag, ".busy"},  32'(busy),  32'(b));
        checkOutput({tag, ".done"},  32'(done),  32'(d));
        checkOutput({tag, ".cout"},  32'(cout),  32'(c));
    endtask

    function automatic logic [NREQ*CW-1:0] packLen(input int l3, input int l2, input int l1, input int l0);
        return {CW'(l3), CW'(l2), CW'(l1), CW'(l0)};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus(4'b0000, '0, 1'b0);
        tick();
        tick();
        checkAll("reset", 4'b0000, 1'b0, 4'b0000, 8'd0);
        reset = 1'b0;
        tick();
        checkAll("idle_no_req", 4'b0000, 1'b0, 4'b0000, 8'd0);

        // Single job, len0=3: grant cycles 1-4, cout 0,1,2, done in cycle 4.
        applyStimulus(4'b0001, packLen(0, 0, 0, 3), 1'b0);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            tick();
            if (cyc == 1) applyStimulus(4'b0000, packLen(0, 0, 0, 3), 1'b0);
            checkAll($sformatf("single_c%0d", cyc), 4'b0001, 1'b1,
                     (cyc == 4) ? 4'b0001 : 4'b0000, CW'((cyc == 4) ? 2 : cyc - 1));
        end
        tick();
        checkAll("single_c5", 4'b0000, 1'b0, 4'b0000, 8'd0);

        // Zero-length job for requester 2: grant and done together, then idle.
        applyStimulus(4'b0100, packLen(0, 0, 0, 0), 1'b0);
        tick();
        applyStimulus(4'b0000, packLen(0, 0, 0, 0), 1'b0);
        checkAll("zero_c1", 4'b0100, 1'b1, 4'b0100, 8'd0);
        tick();
        checkAll("zero_c2", 4'b0000, 1'b0, 4'b0000, 8'd0);

        // Round-robin from a fresh reset with all requesters active.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(4'b1111, packLen(1, 1, 1, 1), 1'b0);
        for (int j = 0; j < 5; j++) begin
            tick();
            checkAll($sformatf("rr%0d_run", j), 4'(1 << (j % 4)), 1'b1, 4'b0000, 8'd0);
            tick();
            if (j == 4) applyStimulus(4'b0000, packLen(1, 1, 1, 1), 1'b0);
            checkAll($sformatf("rr%0d_done", j), 4'(1 << (j % 4)), 1'b1, 4'(1 << (j % 4)), 8'd0);
            tick();
            checkAll($sformatf("rr%0d_idle", j), 4'b0000, 1'b0, 4'b0000, 8'd0);
        end

        // Abort of requester 1 at cout=4; ptr then sits at 2.
        applyStimulus(4'b0010, packLen(0, 0, 10, 0), 1'b0);
        tick();
        applyStimulus(4'b0000, packLen(0, 0, 10, 0), 1'b0);
        checkAll("abort_c1", 4'b0010, 1'b1, 4'b0000, 8'd0);
        for (int cyc = 2; cyc <= 5; cyc++) tick();
        checkAll("abort_c5", 4'b0010, 1'b1, 4'b0000, 8'd4);
        applyStimulus(4'b0000, packLen(0, 0, 10, 0), 1'b1);
        tick();
        checkAll("abort_after", 4'b0000, 1'b0, 4'b0000, 8'd0);
        // Abort held in IDLE must not block arbitration; scan from 2 picks requester 3.
        applyStimulus(4'b1001, packLen(0, 0, 0, 0), 1'b1);
        tick();
        applyStimulus(4'b0000, packLen(0, 0, 0, 0), 1'b0);
        checkAll("abort_next", 4'b1000, 1'b1, 4'b1000, 8'd0);
        tick();
        checkAll("abort_idle", 4'b0000, 1'b0, 4'b0000, 8'd0);

        // Requester 0 zero-length job moves ptr to 1, then requester 2 starts a long job.
        applyStimulus(4'b0001, packLen(0, 20, 0, 0), 1'b0);
        tick();
        applyStimulus(4'b0000, packLen(0, 20, 0, 0), 1'b0);
        checkAll("pre_reset_job0", 4'b0001, 1'b1, 4'b0001, 8'd0);
        tick();
        applyStimulus(4'b0100, packLen(0, 20, 0, 0), 1'b0);
        tick();
        applyStimulus(4'b0000, packLen(0, 20, 0, 0), 1'b0);
        checkAll("mid_run_c1", 4'b0100, 1'b1, 4'b0000, 8'd0);
        for (int cyc = 2; cyc <= 6; cyc++) tick();
        checkAll("mid_run_c6", 4'b0100, 1'b1, 4'b0000, 8'd5);
        #3;
        reset = 1'b1;
        #1;
        checkAll("async_reset", 4'b0000, 1'b0, 4'b0000, 8'd0);
        #2;
        reset = 1'b0;
        // With ptr back at 0, requester 0 beats requester 3.
        applyStimulus(4'b1001, packLen(0, 0, 0, 0), 1'b0);
        tick();
        applyStimulus(4'b0000, packLen(0, 0, 0, 0), 1'b0);
        checkAll("post_reset_grant", 4'b0001, 1'b1, 4'b0001, 8'd0);
        tick();
        checkAll("post_reset_idle", 4'b0000, 1'b0, 4'b0000, 8'd0);

        // Max length with req drop and len change mid-run; ptr=1 so scan wraps to 0.
        applyStimulus(4'b0001, packLen(0, 0, 0, 255), 1'b0);
        for (int cyc = 1; cyc <= 256; cyc++) begin
            tick();
            if (cyc == 2) applyStimulus(4'b0000, packLen(0, 0, 0, 5), 1'b0);
            if (cyc == 1 || cyc == 2 || cyc == 6 || cyc == 128 || cyc >= 254) begin
                checkAll($sformatf("max_c%0d", cyc), 4'b0001, 1'b1,
                         (cyc == 256) ? 4'b0001 : 4'b0000, CW'((cyc == 256) ? 254 : cyc - 1));
            end
        end
        tick();
        checkAll("max_c257", 4'b0000, 1'b0, 4'b0000, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
